// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs feed two registered CDB channels via rotating priority.
// Latency: accept -> broadcast one cycle later (same edge when CDB_BYPASS_EN lets an idle source skip its FIFO).
// Backpressure: src_ready drops when a source FIFO is full, on flush, or while rdy_in is low; rdy_in low freezes all state.
module cdb_arbiter #(
    parameter int NSRC       = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_BITS    = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    RoB_clear,
    input  logic [NSRC-1:0]         src_valid,
    input  logic [NSRC*ID_BITS-1:0] src_id,
    input  logic [NSRC*32-1:0]      src_value,
    output logic [NSRC-1:0]         src_ready,
    output logic                    cdb1_rdy,
    output logic [ID_BITS-1:0]      cdb1_id,
    output logic [31:0]             cdb1_value,
    output logic                    cdb2_rdy,
    output logic [ID_BITS-1:0]      cdb2_id,
    output logic [31:0]             cdb2_value
);

    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = ID_BITS + 32;

    logic [DW-1:0]      mem_q    [NSRC][FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q [NSRC];
    logic [AW-1:0]      rd_ptr_q [NSRC];
    logic [CW-1:0]      cnt_q    [NSRC];
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               cdb1_rdy_q, cdb2_rdy_q;
    logic [ID_BITS-1:0] cdb1_id_q, cdb2_id_q;
    logic [31:0]        cdb1_value_q, cdb2_value_q;

    logic [NSRC-1:0]    accept, cand, grant, pop, push;
    logic [DW-1:0]      in_dat   [NSRC];
    logic [DW-1:0]      head_dat [NSRC];
    logic               g1_vld, g2_vld;
    logic [PW-1:0]      g1_idx, g2_idx;
    logic [DW-1:0]      g1_dat, g2_dat;

    // Per-source acceptance, head selection and candidate set
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_ready[i] = rdy_in && !RoB_clear && (cnt_q[i] < CW'(FIFO_DEPTH));
            accept[i]    = src_valid[i] && src_ready[i];
            in_dat[i]    = {src_id[i*ID_BITS +: ID_BITS], src_value[i*32 +: 32]};
`ifdef CDB_BYPASS_EN
            // An empty source may hand its incoming result straight to a channel
            head_dat[i]  = (cnt_q[i] != '0) ? mem_q[i][rd_ptr_q[i]] : in_dat[i];
            cand[i]      = (cnt_q[i] != '0) || accept[i];
`else
            head_dat[i]  = mem_q[i][rd_ptr_q[i]];
            cand[i]      = (cnt_q[i] != '0);
`endif
        end
    end

    // Rotating-priority scan: first candidate from rr_ptr takes CDB1, second takes CDB2
    always_comb begin
        int          j;
        logic [PW-1:0] jj;
        g1_vld = 1'b0;
        g2_vld = 1'b0;
        g1_idx = '0;
        g2_idx = '0;
        grant  = '0;
        j      = 0;
        jj     = '0;
        for (int k = 0; k < NSRC; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NSRC) j = j - NSRC;
            jj = PW'(j);
            if (cand[jj]) begin
                if (!g1_vld) begin
                    g1_vld    = 1'b1;
                    g1_idx    = jj;
                    grant[jj] = 1'b1;
                end else if (!g2_vld) begin
                    g2_vld    = 1'b1;
                    g2_idx    = jj;
                    grant[jj] = 1'b1;
                end
            end
        end
        g1_dat = head_dat[g1_idx];
        g2_dat = head_dat[g2_idx];
    end

    // FIFO pop/push decisions and next rotation pointer (one past the last winner)
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            pop[i]  = grant[i] && (cnt_q[i] != '0);
            // A granted result taken from an empty FIFO bypasses storage
            push[i] = accept[i] && !(grant[i] && (cnt_q[i] == '0));
        end
        rr_ptr_d = rr_ptr_q;
        if (g2_vld)
            rr_ptr_d = (g2_idx == PW'(NSRC - 1)) ? '0 : g2_idx + PW'(1);
        else if (g1_vld)
            rr_ptr_d = (g1_idx == PW'(NSRC - 1)) ? '0 : g1_idx + PW'(1);
    end

    // Control state: pointers, counts, rotation and registered CDB channels
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_ptr_q     <= '0;
            cdb1_rdy_q   <= 1'b0;
            cdb1_id_q    <= '0;
            cdb1_value_q <= '0;
            cdb2_rdy_q   <= 1'b0;
            cdb2_id_q    <= '0;
            cdb2_value_q <= '0;
        end else if (rdy_in) begin
            if (RoB_clear) begin
                for (int i = 0; i < NSRC; i++) begin
                    wr_ptr_q[i] <= '0;
                    rd_ptr_q[i] <= '0;
                    cnt_q[i]    <= '0;
                end
                rr_ptr_q   <= '0;
                cdb1_rdy_q <= 1'b0;
                cdb2_rdy_q <= 1'b0;
            end else begin
                for (int i = 0; i < NSRC; i++) begin
                    if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                    if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                    cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
                end
                rr_ptr_q   <= rr_ptr_d;
                cdb1_rdy_q <= g1_vld;
                cdb2_rdy_q <= g2_vld;
                if (g1_vld) {cdb1_id_q, cdb1_value_q} <= g1_dat;
                if (g2_vld) {cdb2_id_q, cdb2_value_q} <= g2_dat;
            end
        end
    end

    // FIFO storage; push already implies rdy_in high and no flush
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NSRC; i++) begin
            if (!rst_in && push[i]) mem_q[i][wr_ptr_q[i]] <= in_dat[i];
        end
    end

    assign cdb1_rdy   = cdb1_rdy_q;
    assign cdb1_id    = cdb1_id_q;
    assign cdb1_value = cdb1_value_q;
    assign cdb2_rdy   = cdb2_rdy_q;
    assign cdb2_id    = cdb2_id_q;
    assign cdb2_value = cdb2_value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter with NSRC=3, FIFO_DEPTH=4, ID_BITS=4.
// Vectors apply for one cycle: src_ready checked mid-cycle, CDB outputs checked just after the edge.
// Value encoding: bits [31:24] carry the source index so broadcasts can be traced to their source.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic [2:0]  sv;
    logic [11:0] sid;
    logic [95:0] sval;
    logic [2:0]  srdy;
    logic        c1_rdy, c2_rdy;
    logic [3:0]  c1_id, c2_id;
    logic [31:0] c1_val, c2_val;

    int errors = 0;
    int checks = 0;

    int acc [3];
    int bc  [3];
    int saw_full;

    cdb_arbiter #(.NSRC(3), .FIFO_DEPTH(4), .ID_BITS(4)) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .rdy_in    (rdy),
        .RoB_clear (clr),
        .src_valid (sv),
        .src_id    (sid),
        .src_value (sval),
        .src_ready (srdy),
        .cdb1_rdy  (c1_rdy),
        .cdb1_id   (c1_id),
        .cdb1_value(c1_val),
        .cdb2_rdy  (c2_rdy),
        .cdb2_id   (c2_id),
        .cdb2_value(c2_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic       clr;
        logic [2:0] vld;
        logic [3:0] i0, i1, i2;
        logic [2:0] srdy;
        logic       e1v;
        int         e1s;
        logic [3:0] e1id;
        logic       e2v;
        int         e2s;
        logic [3:0] e2id;
    } vec_t;

    vec_t tbl [28];

    function automatic logic [31:0] mkval(input int s, input logic [3:0] id);
        logic [31:0] r;
        r = {8'(s), 4'h0, id, 16'hBEEF};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2);
        sv   = v;
        sid  = {i2, i1, i0};
        sval = {mkval(2, i2), mkval(1, i1), mkval(0, i0)};
    endtask

    // Checks one channel during the backpressure run against per-source order
    task automatic bp_chan(input string nm, input logic v, input logic [3:0] id, input logic [31:0] val);
        int s;
        if (v) begin
            s = int'(val[31:24]);
            if (s > 2) begin
                checks++;
                errors++;
                $display("FAIL %s: got source %0d expected source 0..2", nm, s);
            end else begin
                chk({nm, "_pending"}, 64'(bc[s] < acc[s]), 64'(1));
                chk({nm, "_order"}, {28'h0, id, val}, {28'h0, 4'(bc[s]), mkval(s, 4'(bc[s]))});
                bc[s]++;
            end
        end
    endtask

    initial begin
        // rdy, clr, vld, i0, i1, i2, srdy, e1v, e1s, e1id, e2v, e2s, e2id
        tbl[0]  = '{1, 0, 3'b111,  1,  2,  3, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 1, 1,  2, 1, 2, 3};
        tbl[2]  = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 1, 0,  1, 0, 0, 0};
        tbl[3]  = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[4]  = '{1, 0, 3'b011,  4,  5,  0, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[5]  = '{1, 1, 3'b010,  0,  6,  0, 3'b000, 0, 0,  0, 0, 0, 0};
        tbl[6]  = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[7]  = '{1, 0, 3'b111,  7,  8,  9, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[8]  = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 1, 0,  7, 1, 1, 8};
        tbl[9]  = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 1, 2,  9, 0, 0, 0};
        tbl[10] = '{1, 0, 3'b111, 10, 11, 12, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[11] = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 1, 0, 10, 1, 1, 11};
        tbl[12] = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 1, 2, 12, 0, 0, 0};
        tbl[13] = '{1, 0, 3'b001, 13,  0,  0, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[14] = '{1, 0, 3'b001, 14,  0,  0, 3'b111, 1, 0, 13, 0, 0, 0};
        tbl[15] = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 1, 0, 14, 0, 0, 0};
        tbl[16] = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[17] = '{1, 0, 3'b101,  1,  0,  2, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[18] = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 1, 2,  2, 1, 0, 1};
        tbl[19] = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[20] = '{1, 1, 3'b000,  0,  0,  0, 3'b000, 0, 0,  0, 0, 0, 0};
        tbl[21] = '{1, 0, 3'b111,  1,  2,  3, 3'b111, 0, 0,  0, 0, 0, 0};
        tbl[22] = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 1, 0,  1, 1, 1, 2};
        tbl[23] = '{0, 0, 3'b111,  9,  9,  9, 3'b000, 1, 0,  1, 1, 1, 2};
        tbl[24] = '{0, 0, 3'b111,  9,  9,  9, 3'b000, 1, 0,  1, 1, 1, 2};
        tbl[25] = '{0, 0, 3'b111,  9,  9,  9, 3'b000, 1, 0,  1, 1, 1, 2};
        tbl[26] = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 1, 2,  3, 0, 0, 0};
        tbl[27] = '{1, 0, 3'b000,  0,  0,  0, 3'b111, 0, 0,  0, 0, 0, 0};

        // Reset held two cycles with every source presenting a result
        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        drive(3'b111, 4'd1, 4'd2, 4'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cdb1_rdy", 64'(c1_rdy), 64'(0));
        chk("rst_cdb2_rdy", 64'(c2_rdy), 64'(0));
        chk("rst_cdb1_data", {28'h0, c1_id, c1_val}, 64'(0));
        chk("rst_cdb2_data", {28'h0, c2_id, c2_val}, 64'(0));
        rst = 1'b0;
        drive(3'b000, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        chk("rst_src_ready", 64'(srdy), 64'(3'b111));
        @(posedge clk);
        #1;
        chk("rst_empty", {62'h0, c1_rdy, c2_rdy}, 64'(0));

        // Single ALU result: one cycle through the FIFO, then one-cycle pulse on CDB1
        drive(3'b001, 4'd5, 4'd0, 4'd0);
        sval[31:0] = 32'h1234;
        @(negedge clk);
        chk("single_ready", 64'(srdy), 64'(3'b111));
        @(posedge clk);
        #1;
        chk("single_not_yet", 64'(c1_rdy), 64'(0));
        drive(3'b000, 4'd0, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        chk("single_cdb1", {27'h0, c1_rdy, c1_id, c1_val}, {27'h0, 1'b1, 4'd5, 32'h1234});
        chk("single_cdb2_rdy", 64'(c2_rdy), 64'(0));
        @(posedge clk);
        #1;
        chk("single_pulse_end", 64'(c1_rdy), 64'(0));

        // Directed vectors: contention, flush, push+pop, wrap order, stall
        for (int v = 0; v < 28; v++) begin
            rdy = tbl[v].rdy;
            clr = tbl[v].clr;
            drive(tbl[v].vld, tbl[v].i0, tbl[v].i1, tbl[v].i2);
            @(negedge clk);
            chk($sformatf("v%0d_src_ready", v), 64'(srdy), 64'(tbl[v].srdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cdb1_rdy", v), 64'(c1_rdy), 64'(tbl[v].e1v));
            if (tbl[v].e1v)
                chk($sformatf("v%0d_cdb1_data", v), {28'h0, c1_id, c1_val},
                    {28'h0, tbl[v].e1id, mkval(tbl[v].e1s, tbl[v].e1id)});
            chk($sformatf("v%0d_cdb2_rdy", v), 64'(c2_rdy), 64'(tbl[v].e2v));
            if (tbl[v].e2v)
                chk($sformatf("v%0d_cdb2_data", v), {28'h0, c2_id, c2_val},
                    {28'h0, tbl[v].e2id, mkval(tbl[v].e2s, tbl[v].e2id)});
        end

        // Backpressure: all sources push every cycle, so FIFOs fill and src_ready must drop at count 4
        rdy = 1'b1;
        clr = 1'b0;
        saw_full = 0;
        for (int i = 0; i < 3; i++) begin
            acc[i] = 0;
            bc[i]  = 0;
        end
        for (int c = 0; c < 14; c++) begin
            drive(3'b111, 4'(acc[0]), 4'(acc[1]), 4'(acc[2]));
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("bp%0d_ready%0d", c, i), 64'(srdy[i]), 64'((acc[i] - bc[i]) < 4));
            end
            if (!srdy[1]) saw_full = 1;
            for (int i = 0; i < 3; i++) begin
                if (srdy[i]) acc[i]++;
            end
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_cdb_order", c), 64'(c2_rdy && !c1_rdy), 64'(0));
            bp_chan("bp_cdb1", c1_rdy, c1_id, c1_val);
            bp_chan("bp_cdb2", c2_rdy, c2_id, c2_val);
        end
        chk("bp_lsb_full_seen", 64'(saw_full), 64'(1));
        drive(3'b000, 4'd0, 4'd0, 4'd0);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("drain%0d_cdb_order", c), 64'(c2_rdy && !c1_rdy), 64'(0));
            bp_chan("drain_cdb1", c1_rdy, c1_id, c1_val);
            bp_chan("drain_cdb2", c2_rdy, c2_id, c2_val);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_all_broadcast_src%0d", i), 64'(bc[i]), 64'(acc[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
